// File: rtl/athena_pkg.sv
// Shared types and defaults for the Athena side-RAM hiscore sequencer.
// Holds the side-RAM request bundle, table geometry defaults and the sequencer state set.
package athena;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data_in;
    logic        nCS;
    logic        nWE;
  } side_ram_t;

  localparam logic [10:0] HS_BASE_ADDR_DEFAULT = 11'h650;
  localparam logic [6:0]  HS_LENGTH_DEFAULT    = 7'h72;

  typedef enum logic [2:0] {
    HS_IDLE,
    HS_WAIT_BASE,
    HS_R_RD,
    HS_R_WR,
    HS_S_RD,
    HS_S_CAP,
    HS_FIN
  } hs_seq_state_t;

  localparam side_ram_t SIDE_RAM_IDLE = '{addr: 11'h000, data_in: 8'h00, nCS: 1'b1, nWE: 1'b1};

  // The table never crosses the top of the 11-bit space, so a plain add is enough.
  function automatic logic [10:0] hs_addr(input logic [10:0] base, input logic [6:0] idx);
    return base + {4'b0000, idx};
  endfunction

endpackage

// File: rtl/athena_side_ram_arb.sv
// Side-RAM grant mux: the game CPU always wins; the sequencer only gets cycles the CPU leaves free.
module athena_side_ram_arb
  import athena::*;
(
  input  side_ram_t cpu_req_i,
  input  side_ram_t seq_req_i,
  output side_ram_t grant_o
);

  always_comb begin
    grant_o = cpu_req_i;
    if (cpu_req_i.nCS && !seq_req_i.nCS) begin
      grant_o = seq_req_i;
    end
  end

endmodule

// File: rtl/athena_hiscore_seq.sv
// Copies the hiscore table between the game side RAM and a staging buffer,
// restoring once per reset and saving on host request, without disturbing the CPU.
module athena_hiscore_seq
  import athena::*;
#(
  parameter logic [10:0] BASE_ADDR = HS_BASE_ADDR_DEFAULT,
  parameter logic [6:0]  LENGTH    = HS_LENGTH_DEFAULT
) (
  input  logic       game_clk,
  input  logic       reset_n,
  input  logic       base_written,
  input  logic       restore_valid,
  input  logic       save_req,
  input  side_ram_t  cpu_ram,
  output side_ram_t  ram_out,
  input  logic [7:0] ram_rd_data,
  output logic [6:0] buf_addr,
  input  logic [7:0] buf_rd_data,
  output logic       buf_wr,
  output logic [7:0] buf_wr_data,
  output logic       busy,
  output logic       done
);

  hs_seq_state_t state_q, state_d;
  logic [6:0]    idx_q, idx_d;
  logic [7:0]    hold_q, hold_d;
  logic          wr_first_q, wr_first_d;
  logic          restore_pend_q, restore_pend_d;
  logic          save_pend_q, save_pend_d;
  logic          restore_done_q, restore_done_d;
  side_ram_t     seq_req;
  logic          cpu_free;
  logic          last_byte;

  assign cpu_free  = cpu_ram.nCS;
  assign last_byte = (idx_q == (LENGTH - 7'd1));
  assign busy      = (state_q != HS_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d        = state_q;
    idx_d          = idx_q;
    hold_d         = hold_q;
    wr_first_d     = 1'b0;
    restore_done_d = restore_done_q;
    restore_pend_d = restore_pend_q | restore_valid;
    save_pend_d    = save_pend_q | save_req;
    seq_req        = SIDE_RAM_IDLE;
    buf_addr       = 7'h00;
    buf_wr         = 1'b0;
    buf_wr_data    = 8'h00;
    done           = 1'b0;

    unique case (state_q)
      HS_IDLE: begin
        if (restore_pend_q) begin
          state_d = HS_WAIT_BASE;
        end else if (save_pend_q && base_written) begin
          state_d     = HS_S_RD;
          idx_d       = 7'h00;
          save_pend_d = save_req;
        end
      end
      HS_WAIT_BASE: begin
        if (base_written) begin
          state_d        = HS_R_RD;
          idx_d          = 7'h00;
          restore_done_d = 1'b1;
        end
      end
      HS_R_RD: begin
        buf_addr   = idx_q;
        wr_first_d = 1'b1;
        state_d    = HS_R_WR;
      end
      HS_R_WR: begin
        buf_addr = idx_q;
        // Buffer data is only valid on the first R_WR cycle; keep it while the CPU holds the RAM.
        hold_d   = wr_first_q ? buf_rd_data : hold_q;
        if (cpu_free) begin
          seq_req = '{addr: hs_addr(BASE_ADDR, idx_q), data_in: hold_d, nCS: 1'b0, nWE: 1'b0};
          if (last_byte) begin
            state_d = HS_FIN;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = HS_R_RD;
          end
        end
      end
      HS_S_RD: begin
        if (cpu_free) begin
          seq_req = '{addr: hs_addr(BASE_ADDR, idx_q), data_in: 8'h00, nCS: 1'b0, nWE: 1'b1};
          state_d = HS_S_CAP;
        end
      end
      HS_S_CAP: begin
        buf_addr    = idx_q;
        buf_wr      = 1'b1;
        buf_wr_data = ram_rd_data;
        if (last_byte) begin
          state_d = HS_FIN;
        end else begin
          idx_d   = idx_q + 7'd1;
          state_d = HS_S_RD;
        end
      end
      HS_FIN: begin
        done    = 1'b1;
        state_d = HS_IDLE;
      end
      default: state_d = HS_IDLE;
    endcase

    // A restore that has already started never re-arms until the next reset.
    restore_pend_d = restore_pend_d & ~restore_done_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= HS_IDLE;
      idx_q          <= 7'h00;
      hold_q         <= 8'h00;
      wr_first_q     <= 1'b0;
      restore_pend_q <= 1'b0;
      save_pend_q    <= 1'b0;
      restore_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      hold_q         <= hold_d;
      wr_first_q     <= wr_first_d;
      restore_pend_q <= restore_pend_d;
      save_pend_q    <= save_pend_d;
      restore_done_q <= restore_done_d;
    end
  end

  athena_side_ram_arb u_arb (
    .cpu_req_i (cpu_ram),
    .seq_req_i (seq_req),
    .grant_o   (ram_out)
  );

endmodule

// File: tb/tb_athena_hiscore_seq.sv
// Scoreboard bench for athena_hiscore_seq: expected RAM writes, buffer writes and done pulses are
// queued when an operation is launched and a negedge monitor pops and compares them as they appear.
module tb_athena_hiscore_seq;
  import athena::*;

  localparam logic [10:0] BASE = HS_BASE_ADDR_DEFAULT;
  localparam int          LEN  = 'h72;

  logic       game_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       base_written = 1'b0;
  logic       restore_valid = 1'b0;
  logic       save_req = 1'b0;
  side_ram_t  cpu_ram;
  side_ram_t  ram_out;
  logic [7:0] ram_rd_data;
  logic [6:0] buf_addr;
  logic [7:0] buf_rd_data;
  logic       buf_wr;
  logic [7:0] buf_wr_data;
  logic       busy;
  logic       done;

  always #5 game_clk = ~game_clk;

  athena_hiscore_seq dut (
    .game_clk      (game_clk),
    .reset_n       (reset_n),
    .base_written  (base_written),
    .restore_valid (restore_valid),
    .save_req      (save_req),
    .cpu_ram       (cpu_ram),
    .ram_out       (ram_out),
    .ram_rd_data   (ram_rd_data),
    .buf_addr      (buf_addr),
    .buf_rd_data   (buf_rd_data),
    .buf_wr        (buf_wr),
    .buf_wr_data   (buf_wr_data),
    .busy          (busy),
    .done          (done)
  );

  typedef struct {logic [10:0] addr; logic [7:0] data;} ram_wr_t;
  typedef struct {logic [6:0] addr; logic [7:0] data;} buf_wr_t;

  ram_wr_t    exp_wr[$];
  buf_wr_t    exp_buf[$];
  int         exp_done[$];
  logic [7:0] mem [2048];
  logic [7:0] bufmem [128];
  logic [7:0] table_exp [LEN];
  logic [7:0] cpu_exp [int];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_seq_acc = 0;
  int n_seq_wr = 0;
  int n_buf_wr = 0;
  int n_done = 0;
  bit spacing_en = 1'b0;
  bit cpu_rand_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge game_clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge game_clk);
      cyc++;
    end
  end

  // Side RAM and staging buffer, both with one-cycle read latency.
  initial begin
    forever begin
      @(posedge game_clk);
      if (!ram_out.nCS) begin
        if (!ram_out.nWE) mem[ram_out.addr] <= ram_out.data_in;
        else ram_rd_data <= mem[ram_out.addr];
      end
      buf_rd_data <= bufmem[buf_addr];
      if (buf_wr) bufmem[buf_addr] <= buf_wr_data;
    end
  end

  // Game CPU: idle, or random short accesses to low RAM when contention is enabled.
  initial begin
    cpu_ram = SIDE_RAM_IDLE;
    forever begin
      @(posedge game_clk);
      #1;
      if (cpu_rand_en) begin
        cpu_ram.nCS     = 1'($urandom_range(0, 1));
        cpu_ram.nWE     = 1'($urandom_range(0, 1));
        cpu_ram.addr    = 11'($urandom_range(0, 63));
        cpu_ram.data_in = 8'($urandom);
        if (!cpu_ram.nCS && !cpu_ram.nWE) cpu_exp[int'(cpu_ram.addr)] = cpu_ram.data_in;
      end else begin
        cpu_ram = SIDE_RAM_IDLE;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a RAM write, buffer write or done.
  initial begin
    int prev_cyc;
    bit have_prev;
    ram_wr_t rw;
    buf_wr_t bw;
    int tag;
    have_prev = 1'b0;
    prev_cyc  = 0;
    forever begin
      @(negedge game_clk);
      if (!cpu_ram.nCS) begin
        check("cpu_passthrough", 32'(ram_out), 32'(cpu_ram));
      end else if (!ram_out.nCS) begin
        n_seq_acc++;
        if (!ram_out.nWE) begin
          n_seq_wr++;
          if (spacing_en && have_prev) check("restore_byte_spacing", 32'(cyc - prev_cyc), 32'd2);
          have_prev = 1'b1;
          prev_cyc  = cyc;
          check("ram_wr_expected", 32'(exp_wr.size() != 0), 32'd1);
          if (exp_wr.size() != 0) begin
            rw = exp_wr.pop_front();
            check("ram_wr_addr", 32'(ram_out.addr), 32'(rw.addr));
            check("ram_wr_data", 32'(ram_out.data_in), 32'(rw.data));
          end
        end
      end
      if (!spacing_en) have_prev = 1'b0;
      if (buf_wr) begin
        n_buf_wr++;
        check("buf_wr_expected", 32'(exp_buf.size() != 0), 32'd1);
        if (exp_buf.size() != 0) begin
          bw = exp_buf.pop_front();
          check("buf_wr_addr", 32'(buf_addr), 32'(bw.addr));
          check("buf_wr_data", 32'(buf_wr_data), 32'(bw.data));
        end
      end
      if (done) begin
        n_done++;
        check("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) tag = exp_done.pop_front();
      end
    end
  end

  task automatic push_restore();
    for (int i = 0; i < LEN; i++) exp_wr.push_back('{addr: BASE + 11'(i), data: table_exp[i]});
    exp_done.push_back(1);
  endtask

  task automatic push_save();
    for (int i = 0; i < LEN; i++) exp_buf.push_back('{addr: 7'(i), data: table_exp[i]});
    exp_done.push_back(2);
  endtask

  task automatic load_buffer_random();
    for (int i = 0; i < LEN; i++) begin
      table_exp[i] = 8'($urandom);
      bufmem[i]    = table_exp[i];
    end
  endtask

  task automatic pulse_restore();
    restore_valid = 1'b1;
    step();
    restore_valid = 1'b0;
  endtask

  task automatic pulse_save();
    save_req = 1'b1;
    step();
    save_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_wr.delete();
    exp_buf.delete();
    exp_done.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_wr.size() + exp_buf.size() + exp_done.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_outstanding"}, 32'(exp_wr.size() + exp_buf.size() + exp_done.size()), 32'd0);
    repeat (3) step();
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_seq_wr(input int target, input int budget);
    int n = 0;
    while (n_seq_wr < target && n < budget) begin
      step();
      n++;
    end
    check("reach_write_count", 32'(n_seq_wr >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_buf_wr"}, 32'(buf_wr), 32'd0);
    check({name, "_buf_addr"}, 32'(buf_addr), 32'd0);
    check({name, "_buf_wr_data"}, 32'(buf_wr_data), 32'd0);
    check({name, "_ram_out"}, 32'(ram_out), 32'(cpu_ram));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0, w0, bw0, d0;

    #1;
    check_reset_outputs("reset");
    mem[BASE - 11'd1]         = 8'hEE;
    mem[BASE + 11'(LEN)]      = 8'hEE;
    step();
    reset_n = 1'b1;
    step();

    // Restore with a late base_written and an idle CPU.
    for (int i = 0; i < LEN; i++) begin
      table_exp[i] = 8'(i) ^ 8'h5A;
      bufmem[i]    = table_exp[i];
    end
    acc0 = n_seq_acc;
    pulse_restore();
    repeat (20) step();
    check("wait_base_busy", 32'(busy), 32'd1);
    check("wait_base_no_ram", 32'(n_seq_acc), 32'(acc0));
    spacing_en = 1'b1;
    push_restore();
    base_written = 1'b1;
    wait_drain("restore_idle_cpu", 1000);
    spacing_en = 1'b0;
    check("below_table_untouched", 32'(mem[BASE - 11'd1]), 32'hEE);
    check("above_table_untouched", 32'(mem[BASE + 11'(LEN)]), 32'hEE);

    // A second restore_valid after a completed restore is ignored.
    acc0 = n_seq_acc;
    pulse_restore();
    repeat (100) step();
    check("restore_once_no_ram", 32'(n_seq_acc), 32'(acc0));
    check("restore_once_busy", 32'(busy), 32'd0);

    // Save of a randomly preloaded table.
    for (int i = 0; i < LEN; i++) begin
      table_exp[i]            = 8'($urandom);
      mem[BASE + 11'(i)]      = table_exp[i];
    end
    bw0 = n_buf_wr;
    d0  = n_done;
    push_save();
    pulse_save();
    wait_drain("save", 2000);
    check("save_buf_wr_count", 32'(n_buf_wr - bw0), 32'(LEN));
    check("save_done_count", 32'(n_done - d0), 32'd1);

    // Restore under random CPU contention.
    do_reset();
    load_buffer_random();
    cpu_exp.delete();
    cpu_rand_en = 1'b1;
    push_restore();
    pulse_restore();
    wait_drain("restore_cpu_contention", 4000);
    cpu_rand_en = 1'b0;
    repeat (2) step();
    check("cpu_wrote_something", 32'(cpu_exp.num() != 0), 32'd1);
    foreach (cpu_exp[a]) check("cpu_write_landed", 32'(mem[a]), 32'(cpu_exp[a]));

    // save_req mid-restore runs right after the restore completes.
    do_reset();
    load_buffer_random();
    d0 = n_done;
    w0 = n_seq_wr;
    push_restore();
    push_save();
    pulse_restore();
    wait_seq_wr(w0 + 'h30, 500);
    pulse_save();
    wait_drain("restore_then_save", 3000);
    check("restore_then_save_dones", 32'(n_done - d0), 32'd2);

    // Reset mid-restore aborts at once and nothing resumes afterwards.
    do_reset();
    load_buffer_random();
    w0 = n_seq_wr;
    push_restore();
    pulse_restore();
    wait_seq_wr(w0 + 'h40, 500);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_wr.delete();
    exp_buf.delete();
    exp_done.delete();
    step();
    reset_n = 1'b1;
    acc0 = n_seq_acc;
    repeat (200) step();
    check("abort_no_resume_ram", 32'(n_seq_acc), 32'(acc0));
    check("abort_no_resume_busy", 32'(busy), 32'd0);
    load_buffer_random();
    push_restore();
    pulse_restore();
    wait_drain("restore_after_abort", 1000);

    // save_req while the table is not initialised waits for base_written.
    base_written = 1'b0;
    do_reset();
    for (int i = 0; i < LEN; i++) begin
      table_exp[i]       = 8'($urandom);
      mem[BASE + 11'(i)] = table_exp[i];
    end
    acc0 = n_seq_acc;
    pulse_save();
    repeat (50) step();
    check("save_pending_busy", 32'(busy), 32'd0);
    check("save_pending_no_ram", 32'(n_seq_acc), 32'(acc0));
    push_save();
    base_written = 1'b1;
    wait_drain("save_after_base", 2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/athena_hiscore_seq.md
ATHENA_HISCORE_SEQ -- requirements
Module: athena_hiscore_seq

Interface
REQ-001 Parameter BASE_ADDR, 11'h650, first side-RAM byte of the hiscore table.
REQ-002 Parameter LENGTH, 7'h72, table length in bytes; buffer index range 0..LENGTH-1.
REQ-003 game_clk  in  1  sole clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 base_written  in  1  level; game has finished initialising the table.
REQ-006 restore_valid  in  1  pulse; staging buffer holds a loaded hiscore slot.
REQ-007 save_req  in  1  pulse; host requests the table be copied into the buffer.
REQ-008 cpu_ram  in  athena::side_ram_t  game CPU side-RAM request (addr, data_in, nCS, nWE).
REQ-009 ram_out  out  athena::side_ram_t  request driven to side RAM.
REQ-010 ram_rd_data  in  8  side-RAM read data, valid 1 cycle after a read is issued.
REQ-011 buf_addr  out  7  staging-buffer address.
REQ-012 buf_rd_data  in  8  buffer read data, valid 1 cycle after buf_addr.
REQ-013 buf_wr / buf_wr_data  out  1 / 8  buffer write strobe and data.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse at the end of each restore or save.

Function
REQ-016 States: IDLE, WAIT_BASE, R_RD, R_WR, S_RD, S_CAP, FIN.
REQ-017 Side-RAM arbitration: the CPU has absolute priority; the sequencer uses the RAM only in cycles with cpu_ram.nCS=1, otherwise ram_out=cpu_ram combinationally.
REQ-018 IDLE: pending restore -> WAIT_BASE; else pending save with base_written=1 -> S_RD; restore takes priority over save.
REQ-019 WAIT_BASE: stay until base_written=1, then idx<=0 and go to R_RD.
REQ-020 R_RD: buf_addr=idx; next cycle -> R_WR.
REQ-021 R_WR: if cpu_ram.nCS=1, drive addr=BASE_ADDR+idx, data_in=buf_rd_data, nCS=0, nWE=0 for one cycle; else hold in R_WR with buffer data retained in a register.
REQ-022 After the R_WR write: idx=LENGTH-1 -> FIN, else idx+1 and go to R_RD.
REQ-023 S_RD: if cpu_ram.nCS=1, drive addr=BASE_ADDR+idx, nCS=0, nWE=1 and go to S_CAP; else hold.
REQ-024 S_CAP: buf_addr=idx, buf_wr=1, buf_wr_data=ram_rd_data; idx=LENGTH-1 -> FIN, else idx+1 -> S_RD.
REQ-025 FIN: done=1 for one cycle, then IDLE.
REQ-026 restore_valid / save_req received in any state set a sticky pending flag, cleared when the matching operation leaves IDLE or WAIT_BASE.
REQ-027 A restore runs at most once per reset; a restore_valid pulse after a completed restore is ignored.
REQ-028 A save_req while base_written=0 stays pending until base_written=1.
REQ-029 Address arithmetic is 11-bit; BASE_ADDR+LENGTH-1 does not wrap (6C1).
REQ-030 The sequencer never drives nCS=0 in a cycle where cpu_ram.nCS=0.

Reset
REQ-031 reset_n low at any time, including mid-transfer, aborts: state=IDLE, idx=0, pending flags=0, restore-done flag=0, busy=0, done=0, buf_wr=0, buf_addr=0, buf_wr_data=0; ram_out follows cpu_ram.
REQ-032 An aborted transfer is not resumed after reset release.

Structure
REQ-033 BASE_ADDR default, LENGTH default and the state enum hs_seq_state_t belong in the athena package beside side_ram_t.
REQ-034 The side-RAM grant mux is a sub-module athena_side_ram_arb: CPU request, sequencer request, grant out; purely combinational.

Verification
REQ-035 restore_valid, then base_written 20 cycles later, CPU idle; buffer 0..71 = i^8'h5A -> RAM 650..6C1 written with i^8'h5A, 2 cycles per byte, single done at completion.
REQ-036 Restore with the CPU asserting nCS every other R_WR cycle -> no sequencer write collides with a CPU access, all 0x72 bytes correct, CPU writes reach RAM unchanged.
REQ-037 RAM 650..6C1 preloaded, save_req -> buffer 0..71 matches RAM, buf_wr asserted exactly 0x72 times, done pulses once.
REQ-038 save_req during restore idx=0x30 -> restore completes, then save starts automatically; two done pulses.
REQ-039 reset_n low at restore idx=0x40 -> outputs at reset values same cycle; after release, no RAM writes until a new restore_valid and base_written.
REQ-040 save_req with base_written=0 -> busy=0, no RAM access; base_written asserts -> save runs.
